secure_memory_cipher_mc: RTL

//  Parametrised multi-cycle Nios II custom-instruction cipher for the secure-memory path; successor to the single-cycle XOR scrambler.

---
 rtl/secure_memory_cipher_mc_if.sv | 22 ++
 rtl/secure_memory_cipher_mc.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/secure_memory_cipher_mc_if.sv
// Custom-instruction bus for the secure-memory cipher.
// The CPU slot is the master; the cipher is the slave.
interface secure_memory_cipher_mc_if #(
    parameter int DATA_W = 32
);
    logic              start;
    logic [1:0]        n;
    logic [DATA_W-1:0] dataa;
    logic [DATA_W-1:0] datab;
    logic [DATA_W-1:0] result;
    logic              done;

    modport master (
        output start, n, dataa, datab,
        input  result, done
    );

    modport slave (
        input  start, n, dataa, datab,
        output result, done
    );
endinterface

// File: rtl/secure_memory_cipher_mc.sv
// Multi-cycle key-XOR/rotate cipher with address tweak and loadable key.
// Optional key lock: define SECMEM_KEY_LOCK_EN to make the first key load sticky.
module secure_memory_cipher_mc #(
    parameter int                DATA_W   = 32,
    parameter int                ROUNDS   = 4,
    parameter int                ROT      = 7,
    parameter logic [DATA_W-1:0] KEY_INIT = DATA_W'(32'h95DA4EAB)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      clk_en,
    secure_memory_cipher_mc_if.slave  bus
);

    localparam int         DROT = (ROUNDS - 1) % DATA_W;
    localparam logic [7:0] LAST = 8'(ROUNDS - 1);
    localparam logic [7:0] RND8 = 8'(ROUNDS);

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    function automatic logic [DATA_W-1:0] rotl(
        input logic [DATA_W-1:0] v,
        input int                s
    );
        if (s == 0) return v;
        return (v << s) | (v >> (DATA_W - s));
    endfunction

    function automatic logic [DATA_W-1:0] rotr(
        input logic [DATA_W-1:0] v,
        input int                s
    );
        if (s == 0) return v;
        return (v >> s) | (v << (DATA_W - s));
    endfunction

    state_t            state_q, state_d;
    logic [7:0]        cnt_q, cnt_d;
    logic [DATA_W-1:0] x_q, x_d;
    logic [DATA_W-1:0] k_q, k_d;
    logic              dec_q, dec_d;
    logic [DATA_W-1:0] key_q, key_d;
    logic [DATA_W-1:0] result_q, result_d;
    logic              done_q, done_d;
    logic              lock_bit;
    logic [DATA_W-1:0] status;
    logic [DATA_W-1:0] k0;
    logic [DATA_W-1:0] nx, nk;

`ifdef SECMEM_KEY_LOCK_EN
    logic lock_q, lock_d;

    // Sticky lock: set by the first key load, cleared only by reset.
    always_ff @(posedge clk) begin
        if (reset) lock_q <= 1'b0;
        else       lock_q <= lock_d;
    end

    assign lock_bit = lock_q;
`else
    assign lock_bit = 1'b0;
`endif

    assign status     = DATA_W'({RND8, 7'b0, lock_bit});
    assign k0         = key_q ^ bus.datab;
    assign bus.result = result_q;
    assign bus.done   = done_q;

    // Next-state: opcode dispatch in IDLE, one round per enabled cycle in RUN.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        x_d      = x_q;
        k_d      = k_q;
        dec_d    = dec_q;
        key_d    = key_q;
        result_d = result_q;
        done_d   = done_q;
        nx       = '0;
        nk       = '0;
`ifdef SECMEM_KEY_LOCK_EN
        lock_d   = lock_q;
`endif
        if (clk_en) begin
            done_d = 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        unique case (bus.n)
                            2'd0: begin
                                x_d     = bus.dataa;
                                k_d     = k0;
                                dec_d   = 1'b0;
                                cnt_d   = '0;
                                state_d = RUN;
                            end
                            2'd1: begin
                                x_d     = bus.dataa;
                                k_d     = rotl(k0, DROT);
                                dec_d   = 1'b1;
                                cnt_d   = '0;
                                state_d = RUN;
                            end
                            2'd2: begin
`ifdef SECMEM_KEY_LOCK_EN
                                if (!lock_q) key_d = bus.dataa;
                                lock_d = 1'b1;
`else
                                key_d = bus.dataa;
`endif
                                result_d = '0;
                                done_d   = 1'b1;
                            end
                            default: begin
                                result_d = status;
                                done_d   = 1'b1;
                            end
                        endcase
                    end
                end
                RUN: begin
                    if (dec_q) begin
                        nx = rotr(x_q, ROT) ^ k_q;
                        nk = rotr(k_q, 1);
                    end else begin
                        nx = rotl(x_q ^ k_q, ROT);
                        nk = rotl(k_q, 1);
                    end
                    x_d   = nx;
                    k_d   = nk;
                    cnt_d = cnt_q + 8'd1;
                    if (cnt_q == LAST) begin
                        result_d = nx;
                        done_d   = 1'b1;
                        state_d  = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            x_q      <= '0;
            k_q      <= '0;
            dec_q    <= 1'b0;
            key_q    <= KEY_INIT;
            result_q <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            x_q      <= x_d;
            k_q      <= k_d;
            dec_q    <= dec_d;
            key_q    <= key_d;
            result_q <= result_d;
            done_q   <= done_d;
        end
    end

endmodule
